// File: rtl/wb_adapter_pkg.sv
// Shared types for the Wishbone classic slave adapter: FSM state encoding and the
// captured-request record at the interconnect's default bus widths.
package wb_adapter_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE,
        RESP
    } adapter_state_t;

    typedef struct packed {
        logic [WB_ADDR_W-1:0]   adr;
        logic [WB_DATA_W/8-1:0] sel;
        logic                   we;
        logic [WB_DATA_W-1:0]   dat;
    } wb_req_t;

endpackage

// File: rtl/wb_classic_slave_adapter_watchdog.sv
// Saturating wait-cycle counter that flags the TIMEOUT-th enabled cycle of a classic access.
module wb_watchdog_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + CNT_W'(1);
        end
    end

    // Asserted during the TIMEOUT-th waited cycle so the owner can give up on that same edge.
    assign expired = enable && (count >= LAST);

endmodule

// File: rtl/wb_classic_slave_adapter.sv
// Bridges one pipelined Wishbone slave port to a variable-latency classic slave, stalling the
// interconnect until the classic result is in hand so ACK/ERR lands one cycle after acceptance.
module wb_classic_slave_adapter
    import wb_adapter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                up_cyc,
    input  logic                up_stb,
    input  logic                up_we,
    input  logic [ADDR_W-1:0]   up_adr,
    input  logic [DATA_W/8-1:0] up_sel,
    input  logic [DATA_W-1:0]   up_dat_i,
    output logic                up_stall,
    output logic                up_ack,
    output logic                up_err,
    output logic [DATA_W-1:0]   up_dat_o,
    output logic                dn_cyc,
    output logic                dn_stb,
    output logic                dn_we,
    output logic [ADDR_W-1:0]   dn_adr,
    output logic [DATA_W/8-1:0] dn_sel,
    output logic [DATA_W-1:0]   dn_dat_o,
    input  logic                dn_ack,
    input  logic                dn_err,
    input  logic [DATA_W-1:0]   dn_dat_i
);

    localparam int SEL_W = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic [SEL_W-1:0]  sel;
        logic              we;
        logic [DATA_W-1:0] dat;
    } req_t;

    adapter_state_t    state;
    adapter_state_t    state_next;
    req_t              req_q;
    req_t              req_d;
    logic              dn_active_q;
    logic              dn_active_d;
    logic              err_flag_q;
    logic              err_flag_d;
    logic              ack_q;
    logic              ack_d;
    logic              err_q;
    logic              err_d;
    logic [DATA_W-1:0] rdat_q;
    logic [DATA_W-1:0] rdat_d;

    logic accept;
    logic expired;
    logic resp_any;
    logic resp_err;

    assign accept   = up_cyc & up_stb;
    assign resp_any = dn_ack | dn_err | expired;
    // A real slave error beats a simultaneous ack; a late ack still beats the watchdog.
    assign resp_err = dn_err | (expired & ~dn_ack);

    wb_watchdog_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == IDLE),
        .enable  (state == REQ),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_q       <= '0;
            dn_active_q <= 1'b0;
            err_flag_q  <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdat_q      <= '0;
        end else begin
            state       <= state_next;
            req_q       <= req_d;
            dn_active_q <= dn_active_d;
            err_flag_q  <= err_flag_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdat_q      <= rdat_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = REQ;
            REQ: begin
                if (!up_cyc) begin
                    state_next = IDLE;
                end else if (resp_any) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = accept ? RESP : IDLE;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values for the registered bus outputs; the response pulse is armed on the
    // RELEASE->RESP edge so it is visible only while the FSM sits in RESP.
    always_comb begin
        req_d       = req_q;
        dn_active_d = dn_active_q;
        err_flag_d  = err_flag_q;
        rdat_d      = rdat_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_d.adr   = up_adr;
                    req_d.sel   = up_sel;
                    req_d.we    = up_we;
                    req_d.dat   = up_dat_i;
                    dn_active_d = 1'b1;
                end
            end
            REQ: begin
                if (!up_cyc) begin
                    dn_active_d = 1'b0;
                end else if (resp_any) begin
                    dn_active_d = 1'b0;
                    err_flag_d  = resp_err;
                    rdat_d      = (resp_err || req_q.we) ? '0 : dn_dat_i;
                end
            end
            RELEASE: begin
                if (accept) begin
                    ack_d = ~err_flag_q;
                    err_d = err_flag_q;
                end
            end
            default: ;
        endcase
    end

    assign up_stall = up_cyc & up_stb & (state != RELEASE);
    assign up_ack   = ack_q;
    assign up_err   = err_q;
    assign up_dat_o = rdat_q;
    assign dn_cyc   = dn_active_q;
    assign dn_stb   = dn_active_q;
    assign dn_we    = req_q.we;
    assign dn_adr   = req_q.adr;
    assign dn_sel   = req_q.sel;
    assign dn_dat_o = req_q.dat;

endmodule

// File: tb/tb_wb_classic_slave_adapter.sv
// Drives directed and random transactions through the adapter and checks every cycle against a
// transaction-level model: request cycle, N waited cycles, release cycle, one response cycle.
module tb_wb_classic_slave_adapter;
    import wb_adapter_pkg::*;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int SEL_W    = DATA_W / 8;
    localparam int TIMEOUT  = 4;
    localparam int N_RANDOM = 150;

    typedef enum int {RSP_ACK, RSP_ERR, RSP_BOTH, RSP_SILENT} rsp_kind_t;
    typedef enum int {AB_NONE, AB_REQ, AB_RELEASE} abort_kind_t;

    typedef struct {
        wb_req_t     req;
        int          waits;
        rsp_kind_t   kind;
        abort_kind_t abort;
        int          abort_cyc;
        int          gap;
        logic [31:0] rdata;
    } txn_t;

    logic              clk;
    logic              rst_n;
    logic              up_cyc;
    logic              up_stb;
    logic              up_we;
    logic [ADDR_W-1:0] up_adr;
    logic [SEL_W-1:0]  up_sel;
    logic [DATA_W-1:0] up_dat_i;
    logic              up_stall;
    logic              up_ack;
    logic              up_err;
    logic [DATA_W-1:0] up_dat_o;
    logic              dn_cyc;
    logic              dn_stb;
    logic              dn_we;
    logic [ADDR_W-1:0] dn_adr;
    logic [SEL_W-1:0]  dn_sel;
    logic [DATA_W-1:0] dn_dat_o;
    logic              dn_ack;
    logic              dn_err;
    logic [DATA_W-1:0] dn_dat_i;

    int          num_checks;
    int          num_errors;
    logic [31:0] exp_dat;
    txn_t        txns[$];

    wb_classic_slave_adapter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_cyc   (up_cyc),
        .up_stb   (up_stb),
        .up_we    (up_we),
        .up_adr   (up_adr),
        .up_sel   (up_sel),
        .up_dat_i (up_dat_i),
        .up_stall (up_stall),
        .up_ack   (up_ack),
        .up_err   (up_err),
        .up_dat_o (up_dat_o),
        .dn_cyc   (dn_cyc),
        .dn_stb   (dn_stb),
        .dn_we    (dn_we),
        .dn_adr   (dn_adr),
        .dn_sel   (dn_sel),
        .dn_dat_o (dn_dat_o),
        .dn_ack   (dn_ack),
        .dn_err   (dn_err),
        .dn_dat_i (dn_dat_i)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, actual, expected);
        end
    endtask

    task automatic driveReq(input txn_t t);
        up_cyc   = 1'b1;
        up_stb   = 1'b1;
        up_we    = t.req.we;
        up_adr   = t.req.adr;
        up_sel   = t.req.sel;
        up_dat_i = t.req.dat;
    endtask

    task automatic driveIdle();
        up_cyc   = 1'($urandom_range(0, 1));
        up_stb   = 1'b0;
        up_we    = 1'($urandom);
        up_adr   = $urandom;
        up_sel   = 4'($urandom);
        up_dat_i = $urandom;
    endtask

    task automatic slaveIdle();
        dn_ack   = 1'b0;
        dn_err   = 1'b0;
        dn_dat_i = $urandom;
    endtask

    task automatic checkCommon(input string pfx, input logic s, input logic a, input logic e, input logic d);
        checkOutput({pfx, "_stall"}, 32'(up_stall), 32'(s));
        checkOutput({pfx, "_ack"}, 32'(up_ack), 32'(a));
        checkOutput({pfx, "_err"}, 32'(up_err), 32'(e));
        checkOutput({pfx, "_dn_cyc"}, 32'(dn_cyc), 32'(d));
        checkOutput({pfx, "_dn_stb"}, 32'(dn_stb), 32'(d));
        checkOutput({pfx, "_dat_o"}, up_dat_o, exp_dat);
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
        driveIdle();
        slaveIdle();
        @(negedge clk);
        checkCommon("gap", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One transaction, cycle by cycle, from the IDLE cycle that presents it to RESP or abort.
    task automatic applyStimulus(input txn_t t, input bit have_next, input txn_t nxt);
        int eff;
        int last_req;
        bit resp_cyc;
        bit abort_now;
        eff      = (t.kind == RSP_SILENT) ? TIMEOUT : t.waits + 1;
        last_req = (t.abort == AB_REQ) ? t.abort_cyc : eff;

        @(posedge clk);
        #1;
        driveReq(t);
        slaveIdle();
        @(negedge clk);
        checkCommon("idle", 1'b1, 1'b0, 1'b0, 1'b0);

        for (int n = 1; n <= last_req; n++) begin
            @(posedge clk);
            #1;
            abort_now = (t.abort == AB_REQ) && (n == t.abort_cyc);
            if (abort_now) begin
                up_cyc = 1'b0;
                up_stb = 1'b0;
            end else begin
                driveReq(t);
            end
            slaveIdle();
            resp_cyc = (t.kind != RSP_SILENT) && (n == t.waits + 1);
            if (resp_cyc) begin
                dn_ack   = (t.kind == RSP_ACK) || (t.kind == RSP_BOTH);
                dn_err   = (t.kind == RSP_ERR) || (t.kind == RSP_BOTH);
                dn_dat_i = t.rdata;
            end
            @(negedge clk);
            checkCommon("req", !abort_now, 1'b0, 1'b0, 1'b1);
            checkOutput("req_dn_adr", dn_adr, t.req.adr);
            checkOutput("req_dn_sel", 32'(dn_sel), 32'(t.req.sel));
            checkOutput("req_dn_we", 32'(dn_we), 32'(t.req.we));
            checkOutput("req_dn_dat_o", dn_dat_o, t.req.dat);
            if (t.abort != AB_REQ && n == eff) begin
                exp_dat = (t.kind == RSP_ACK && !t.req.we) ? t.rdata : 32'h0;
            end
        end
        if (t.abort == AB_REQ) return;

        @(posedge clk);
        #1;
        if (t.abort == AB_RELEASE) begin
            up_cyc = 1'b0;
            up_stb = 1'b0;
        end else begin
            driveReq(t);
        end
        slaveIdle();
        @(negedge clk);
        checkCommon("release", 1'b0, 1'b0, 1'b0, 1'b0);
        if (t.abort == AB_RELEASE) return;

        @(posedge clk);
        #1;
        if (have_next && nxt.gap == 0) driveReq(nxt);
        else driveIdle();
        slaveIdle();
        @(negedge clk);
        checkCommon("resp", have_next && nxt.gap == 0, t.kind == RSP_ACK, t.kind != RSP_ACK, 1'b0);
    endtask

    function automatic txn_t mkTxn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                                   input logic [31:0] dat, input int waits, input rsp_kind_t kind,
                                   input abort_kind_t abort, input int abort_cyc, input int gap,
                                   input logic [31:0] rdata);
        txn_t t;
        t.req.we    = we;
        t.req.adr   = adr;
        t.req.sel   = sel;
        t.req.dat   = dat;
        t.waits     = waits;
        t.kind      = kind;
        t.abort     = abort;
        t.abort_cyc = abort_cyc;
        t.gap       = gap;
        t.rdata     = rdata;
        return t;
    endfunction

    function automatic txn_t randTxn();
        txn_t t;
        t = mkTxn(1'($urandom), $urandom, 4'($urandom), $urandom, $urandom_range(0, 3),
                  rsp_kind_t'($urandom_range(0, 3)), AB_NONE, $urandom_range(1, TIMEOUT - 1),
                  $urandom_range(0, 2), $urandom);
        case ($urandom_range(0, 5))
            0: begin
                t.abort = AB_REQ;
                t.kind  = RSP_SILENT;
            end
            1: t.abort = AB_RELEASE;
            default: t.abort = AB_NONE;
        endcase
        return t;
    endfunction

    initial begin
        txn_t t;
        clk      = 1'b0;
        rst_n    = 1'b1;
        up_cyc   = 1'b0;
        up_stb   = 1'b0;
        up_we    = 1'b0;
        up_adr   = '0;
        up_sel   = '0;
        up_dat_i = '0;
        dn_ack   = 1'b0;
        dn_err   = 1'b0;
        dn_dat_i = '0;
        exp_dat  = 32'h0;
        num_checks = 0;
        num_errors = 0;

        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_dn_cyc", 32'(dn_cyc), 32'h0);
        checkOutput("rst_dn_stb", 32'(dn_stb), 32'h0);
        checkOutput("rst_dn_we", 32'(dn_we), 32'h0);
        checkOutput("rst_dn_adr", dn_adr, 32'h0);
        checkOutput("rst_dn_sel", 32'(dn_sel), 32'h0);
        checkOutput("rst_dn_dat_o", dn_dat_o, 32'h0);
        checkOutput("rst_up_ack", 32'(up_ack), 32'h0);
        checkOutput("rst_up_err", 32'(up_err), 32'h0);
        checkOutput("rst_up_dat_o", up_dat_o, 32'h0);
        checkOutput("rst_up_stall", 32'(up_stall), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        txns.push_back(mkTxn(1'b0, 32'h10, 4'hF, 32'h0, 0, RSP_ACK, AB_NONE, 1, 1, 32'hDEADBEEF));
        txns.push_back(mkTxn(1'b1, 32'h20, 4'b0011, 32'h12345678, 3, RSP_ACK, AB_NONE, 1, 1, 32'hCAFEF00D));
        txns.push_back(mkTxn(1'b0, 32'h30, 4'hF, 32'h0, 1, RSP_BOTH, AB_NONE, 1, 0, 32'h55AA55AA));
        txns.push_back(mkTxn(1'b0, 32'h34, 4'hF, 32'h0, 0, RSP_ACK, AB_NONE, 1, 1, 32'h01020304));
        txns.push_back(mkTxn(1'b0, 32'h38, 4'hF, 32'h0, 0, RSP_SILENT, AB_NONE, 1, 1, 32'h0));
        txns.push_back(mkTxn(1'b1, 32'h3C, 4'h1, 32'hA5A5A5A5, 0, RSP_SILENT, AB_REQ, 2, 1, 32'h0));
        txns.push_back(mkTxn(1'b0, 32'h40, 4'hF, 32'h0, 0, RSP_ACK, AB_RELEASE, 1, 0, 32'h0BADCAFE));
        txns.push_back(mkTxn(1'b0, 32'h44, 4'hF, 32'h0, 2, RSP_ACK, AB_NONE, 1, 0, 32'h76543210));
        for (int i = 0; i < N_RANDOM; i++) txns.push_back(randTxn());

        for (int i = 0; i < txns.size(); i++) begin
            repeat (txns[i].gap) idleCycle();
            if (i + 1 < txns.size()) applyStimulus(txns[i], 1'b1, txns[i + 1]);
            else applyStimulus(txns[i], 1'b0, txns[i]);
        end
        repeat (2) idleCycle();

        // Asynchronous reset landing in the middle of a classic access.
        t = mkTxn(1'b0, 32'h80, 4'hF, 32'h0, 0, RSP_SILENT, AB_NONE, 1, 1, 32'h0);
        @(posedge clk);
        #1;
        driveReq(t);
        slaveIdle();
        @(posedge clk);
        #1;
        driveReq(t);
        @(negedge clk);
        checkOutput("pre_rst_dn_cyc", 32'(dn_cyc), 32'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_dat = 32'h0;
        checkOutput("midrst_dn_cyc", 32'(dn_cyc), 32'h0);
        checkOutput("midrst_dn_stb", 32'(dn_stb), 32'h0);
        checkOutput("midrst_dn_adr", dn_adr, 32'h0);
        checkOutput("midrst_dn_we", 32'(dn_we), 32'h0);
        checkOutput("midrst_up_ack", 32'(up_ack), 32'h0);
        checkOutput("midrst_up_err", 32'(up_err), 32'h0);
        checkOutput("midrst_up_dat_o", up_dat_o, 32'h0);
        up_cyc = 1'b0;
        up_stb = 1'b0;
        #1;
        checkOutput("midrst_up_stall", 32'(up_stall), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        idleCycle();
        t = mkTxn(1'b0, 32'h84, 4'hF, 32'h0, 1, RSP_ACK, AB_NONE, 1, 1, 32'h600DF00D);
        applyStimulus(t, 1'b0, t);
        repeat (2) idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/wb_classic_slave_adapter.md
Name: wb_classic_slave_adapter

Overview:
- Downstream stage of the shared-bus pipelined Wishbone interconnect, one instance per slave port.
- Lets a variable-latency Wishbone B4 classic (non-pipelined) slave meet the interconnect's rule that ACK/ERR arrives exactly one cycle after the accepted request.
- Holds STALL high while the classic access runs, releases STALL for one cycle once the result is captured, then responds on the next cycle.
- A watchdog converts a hung slave into an ERR response.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; SEL width is DATA_W/8.
- TIMEOUT, 255, maximum classic wait cycles before forced ERR; legal range 1..65535.

Ports:
- clk  in  1  single clock for both sides.
- rst_n  in  1  asynchronous, active-low reset.
- up_cyc, up_stb, up_we  in  1 each  pipelined request from the interconnect.
- up_adr  in  ADDR_W  request address.
- up_sel  in  DATA_W/8  byte selects.
- up_dat_i  in  DATA_W  write data.
- up_stall  out  1  pipelined stall to the interconnect.
- up_ack, up_err  out  1 each  pipelined response.
- up_dat_o  out  DATA_W  read data.
- dn_cyc, dn_stb, dn_we  out  1 each  classic request to the slave.
- dn_adr  out  ADDR_W  classic address.
- dn_sel  out  DATA_W/8  classic byte selects.
- dn_dat_o  out  DATA_W  classic write data.
- dn_ack, dn_err  in  1 each  classic response.
- dn_dat_i  in  DATA_W  classic read data.

Behaviour:
- Reset (async on rst_n low): state IDLE; all dn_* outputs 0; up_ack=0, up_err=0, up_dat_o=0; watchdog counter 0.
- up_stall is combinational: up_cyc & up_stb & (state != RELEASE). It must be 0 whenever up_stb is low, because the interconnect ORs stall across all slaves.
- IDLE: when up_cyc & up_stb, register adr/sel/we/dat into dn_*, set dn_cyc=dn_stb=1, clear counter, go REQ.
- REQ: dn_* held stable; counter increments each cycle.
  - dn_ack: capture dn_dat_i into up_dat_o if the access is a read, else load 0; err_flag=0; drop dn_cyc/dn_stb; go RELEASE.
  - dn_err: up_dat_o=0; err_flag=1; drop dn_cyc/dn_stb; go RELEASE.
  - dn_ack and dn_err in the same cycle: dn_err wins.
  - Counter reaches TIMEOUT with no response: same as dn_err.
  - up_cyc falls (master abort): drop dn_cyc/dn_stb next edge, discard the access, go IDLE. No up_ack/up_err is ever raised.
- RELEASE: up_stall=0 for this cycle only.
  - up_cyc & up_stb present: request accepted by the interconnect; go RESP.
  - Otherwise (abort): go IDLE, no response.
- RESP: up_ack = ~err_flag, up_err = err_flag, for exactly one cycle; up_dat_o valid. Next state IDLE.
  - A new up_stb seen in RESP is not accepted (stall=1). It is picked up from IDLE on the following cycle.
- up_ack, up_err and up_dat_o are registered. up_ack and up_err are 0 in every state except RESP. up_dat_o holds its value outside RESP.
- Latency: request seen in IDLE at cycle 0 → dn_stb at cycle 1 → zero-wait dn_ack at cycle 1 → RELEASE at cycle 2 → up_ack at cycle 3. Each slave wait state adds 1 cycle.
- Counter width is clog2(TIMEOUT+1) and saturates; it never wraps.
- The captured request is not rechecked in RELEASE; the master is required to hold the request while stalled.

Decomposition:
- Shared package wb_adapter_pkg: state enum (IDLE, REQ, RELEASE, RESP) and a request-capture struct typedef {adr, sel, we, dat}.
- One natural sub-module, wb_watchdog_cnt: clear/enable inputs, parameter TIMEOUT, expired output.

Test Plan:
- Zero-wait read: up_stb at adr 0x10; slave acks in its first REQ cycle with 0xDEADBEEF → up_stall high for cycles 0–1, low at cycle 2, up_ack=1 and up_dat_o=0xDEADBEEF at cycle 3 only.
- Write with 3 wait states, sel=4'b0011, dat=0x12345678 → dn_* stable for 4 cycles; up_ack at cycle 6; up_dat_o=0; up_err=0.
- Slave raises dn_ack and dn_err together → up_err=1, up_ack=0, one cycle.
- TIMEOUT=4, slave silent → dn_cyc drops after 4 REQ cycles; up_err=1 one cycle later than RELEASE.
- Master drops up_cyc in the 2nd REQ cycle → dn_cyc=0 next edge; no up_ack/up_err; state returns to IDLE. Repeat the abort in RELEASE with the same result.
- rst_n pulsed low mid-REQ → all outputs 0 immediately (asynchronous). The next request after reset completes normally. up_stall stays 0 whenever up_stb=0.
